// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
//   - default counter width and reset-time terminal count
//   - FSM state encodings (IDLE, RUN, DRAIN)
//   - st_active(): true for the states in which the counter advances
package clkdiv_pkg;

   localparam int unsigned CLKDIV_WIDTH       = 31;
   localparam int unsigned CLKDIV_DEFAULT_DIV = 10000;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   function automatic logic st_active(input logic [1:0] st);
      return (st == RUN) || (st == DRAIN);
   endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Half-period counter with terminal-count compare and square-wave toggle.
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   enable_i   counter advances while high
//   clear_i    forces count and clk_out to 0; overrides everything but reset
//   term_i     terminal count (half period = term_i + 1 cycles)
//   tc_o       combinational: enabled and count == term_i
//   clk_out_o  registered divided clock, toggles at each terminal count
module clkdiv_core
   import clkdiv_pkg::*;
#(
   parameter int unsigned WIDTH = CLKDIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] term_i,
   output logic             tc_o,
   output logic             clk_out_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             clk_out_q, clk_out_d;

   // Raw compare; the caller masks it with clear_i when it needs the tick.
   assign tc_o      = enable_i && (count_q == term_i);
   assign clk_out_o = clk_out_q;

   always_comb begin
      count_d   = count_q;
      clk_out_d = clk_out_q;
      if (clear_i) begin
         count_d   = '0;
         clk_out_d = 1'b0;
      end else if (tc_o) begin
         count_d   = '0;
         clk_out_d = ~clk_out_q;
      end else if (enable_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q   <= '0;
         clk_out_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         clk_out_q <= clk_out_d;
      end
   end

endmodule

// File: rtl/clkdiv_rate_ctrl.sv
// Run/stop and rate-change controller for the programmable clock divider.
// Ports:
//   clk_in     system clock, rising edge
//   rst        synchronous active-high reset
//   start      pulse: begin generating when idle
//   stop       pulse: stop glitch-free (immediately on a low phase, else drain)
//   div_load   pulse: div_value valid this cycle
//   div_value  new terminal count (half period = div_value + 1 cycles)
//   div_ack    pulse: the loaded value is now active
//   tick       pulse at each terminal count while generating
//   clk_out    divided clock
//   running    high in RUN or DRAIN
//   busy       high while a load is pending or a stop is draining
module clkdiv_rate_ctrl
   import clkdiv_pkg::*;
#(
   parameter int unsigned WIDTH       = CLKDIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_ack,
   output logic             tick,
   output logic             clk_out,
   output logic             running,
   output logic             busy
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pend_div_q, pend_div_d;
   logic             pend_valid_q, pend_valid_d;
   logic             ack_d, ack_q;
   logic             tick_q, running_q, busy_q;
   logic             clear, tc_raw, tc_eff;

   // Outside RUN/DRAIN the counter is held clear; a stop on the low phase
   // clears immediately, which also suppresses a coincident terminal count.
   assign clear  = !st_active(state_q) || ((state_q == RUN) && stop && !clk_out);
   assign tc_eff = tc_raw && !clear;

   clkdiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_i     (clk_in),
      .rst_i     (rst),
      .enable_i  (st_active(state_q)),
      .clear_i   (clear),
      .term_i    (active_q),
      .tc_o      (tc_raw),
      .clk_out_o (clk_out)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) state_d = RUN;
         end
         RUN: begin
            // A stop coincident with a high-phase TC is already the final edge.
            if (stop) begin
               if (!clk_out || tc_eff) state_d = IDLE;
               else                    state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (tc_eff) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      active_d     = active_q;
      pend_div_d   = pend_div_q;
      pend_valid_d = pend_valid_q;
      ack_d        = 1'b0;
      if (!st_active(state_q)) begin
         // Idle: nothing is counting, so a new value may take effect at once.
         // A pending value left over from an immediate stop is flushed here.
         if (div_load) begin
            active_d     = div_value;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
         end else if (pend_valid_q) begin
            active_d     = pend_div_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
         end
      end else begin
         if (tc_eff && pend_valid_q) begin
            active_d     = pend_div_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
         end
         // Captured after the apply so a load on the TC waits for the next one.
         if (div_load) begin
            pend_div_d   = div_value;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= IDLE;
         active_q     <= WIDTH'(DEFAULT_DIV);
         pend_div_q   <= '0;
         pend_valid_q <= 1'b0;
         ack_q        <= 1'b0;
         tick_q       <= 1'b0;
         running_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         pend_div_q   <= pend_div_d;
         pend_valid_q <= pend_valid_d;
         ack_q        <= ack_d;
         tick_q       <= tc_eff;
         running_q    <= st_active(state_d);
         busy_q       <= pend_valid_d || (state_d == DRAIN);
      end
   end

   assign div_ack = ack_q;
   assign tick    = tick_q;
   assign running = running_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_clkdiv_rate_ctrl.sv
module tb_clkdiv_rate_ctrl;

   localparam int unsigned W = 8;

   logic         clk_in;
   logic         rst;
   logic         start;
   logic         stop;
   logic         div_load;
   logic [W-1:0] div_value;
   logic         div_ack;
   logic         tick;
   logic         clk_out;
   logic         running;
   logic         busy;

   int total;
   int bad;

   clkdiv_rate_ctrl #(
      .WIDTH       (W),
      .DEFAULT_DIV (3)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .div_load  (div_load),
      .div_value (div_value),
      .div_ack   (div_ack),
      .tick      (tick),
      .clk_out   (clk_out),
      .running   (running),
      .busy      (busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Steps until tick is seen; n = steps taken (-1 on timeout), acks = div_ack pulses seen.
   task automatic wait_tick(output int n, output int acks);
      n    = -1;
      acks = 0;
      for (int i = 1; i <= 64; i++) begin
         step();
         if (div_ack === 1'b1) acks++;
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      int nt;
      do_reset();
      total++;
      if ({tick, clk_out, div_ack, running, busy} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got=%b want=00000", {tick, clk_out, div_ack, running, busy});
      end
      nt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (tick !== 1'b0 || clk_out !== 1'b0) nt++;
      end
      total++;
      if (nt !== 0) begin
         bad++;
         $display("FAIL idle_quiet: active_cycles=%0d want=0", nt);
      end
   endtask

   task automatic test_start();
      int n, a;
      pulse_start();
      total++;
      if (running !== 1'b1) begin
         bad++;
         $display("FAIL start_running: got=%b want=1", running);
      end
      wait_tick(n, a);
      total++;
      if (n !== 4 || clk_out !== 1'b1) begin
         bad++;
         $display("FAIL start_first_tick: n=%0d clk_out=%b want n=4 clk_out=1", n, clk_out);
      end
      wait_tick(n, a);
      total++;
      if (n !== 4 || clk_out !== 1'b0 || a !== 0) begin
         bad++;
         $display("FAIL start_period: n=%0d clk_out=%b acks=%0d want 4 0 0", n, clk_out, a);
      end
   endtask

   // Runs on from test_start: a low level with div 3 has just begun (count=0).
   task automatic test_load_run();
      int n, a;
      step();
      div_load  = 1'b1;
      div_value = 8'd1;
      step();
      div_load  = 1'b0;
      total++;
      if (busy !== 1'b1 || div_ack !== 1'b0) begin
         bad++;
         $display("FAIL load_run_busy: busy=%b ack=%b want busy=1 ack=0", busy, div_ack);
      end
      // Two cycles of the 4-cycle level already elapsed.
      wait_tick(n, a);
      total++;
      if (n !== 2 || div_ack !== 1'b1 || clk_out !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL load_run_apply: n=%0d ack=%b clk=%b busy=%b want 2 1 1 0",
                  n, div_ack, clk_out, busy);
      end
      wait_tick(n, a);
      total++;
      if (n !== 2 || a !== 0 || clk_out !== 1'b0) begin
         bad++;
         $display("FAIL load_run_new_rate: n=%0d acks=%0d clk=%b want 2 0 0", n, a, clk_out);
      end
      wait_tick(n, a);
      total++;
      if (n !== 2 || clk_out !== 1'b1) begin
         bad++;
         $display("FAIL load_run_new_rate2: n=%0d clk=%b want 2 1", n, clk_out);
      end
   endtask

   task automatic test_idle_load_zero();
      int n, a;
      int ticks;
      do_reset();
      div_load  = 1'b1;
      div_value = 8'd0;
      step();
      div_load  = 1'b0;
      total++;
      if (div_ack !== 1'b1 || busy !== 1'b0 || running !== 1'b0) begin
         bad++;
         $display("FAIL idle_load_ack: ack=%b busy=%b run=%b want 1 0 0", div_ack, busy, running);
      end
      step();
      total++;
      if (div_ack !== 1'b0) begin
         bad++;
         $display("FAIL idle_ack_width: ack=%b want=0", div_ack);
      end
      pulse_start();
      wait_tick(n, a);
      total++;
      if (n !== 1 || clk_out !== 1'b1) begin
         bad++;
         $display("FAIL div0_first: n=%0d clk=%b want 1 1", n, clk_out);
      end
      ticks = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (tick === 1'b1 && clk_out === logic'(i[0] == 1'b0 ? 1'b0 : 1'b1)) ticks++;
      end
      total++;
      if (ticks !== 4) begin
         bad++;
         $display("FAIL div0_every_cycle: good_cycles=%0d want=4", ticks);
      end
   endtask

   task automatic test_stop();
      int n, a;
      int nt;
      do_reset();
      pulse_start();
      wait_tick(n, a);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++;
      if (busy !== 1'b1 || running !== 1'b1 || clk_out !== 1'b1 || tick !== 1'b0) begin
         bad++;
         $display("FAIL drain_enter: busy=%b run=%b clk=%b tick=%b want 1 1 1 0",
                  busy, running, clk_out, tick);
      end
      wait_tick(n, a);
      total++;
      if (n !== 2 || clk_out !== 1'b0 || running !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL drain_final_tick: n=%0d clk=%b run=%b busy=%b want 2 0 0 0",
                  n, clk_out, running, busy);
      end
      nt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tick !== 1'b0 || clk_out !== 1'b0) nt++;
      end
      total++;
      if (nt !== 0) begin
         bad++;
         $display("FAIL drain_then_idle: active_cycles=%0d want=0", nt);
      end
      // Stop on a low phase: immediate, no tick.
      pulse_start();
      wait_tick(n, a);
      wait_tick(n, a);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++;
      if (running !== 1'b0 || tick !== 1'b0 || clk_out !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_low: run=%b tick=%b clk=%b busy=%b want 0 0 0 0",
                  running, tick, clk_out, busy);
      end
      // start and stop together in IDLE: both ignored.
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      nt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (tick !== 1'b0 || running !== 1'b0) nt++;
      end
      total++;
      if (nt !== 0) begin
         bad++;
         $display("FAIL start_stop_idle: active_cycles=%0d want=0", nt);
      end
   endtask

   task automatic test_back_to_back();
      int n, a;
      do_reset();
      pulse_start();
      wait_tick(n, a);
      // High level, div 3, count=0 now.
      div_load  = 1'b1;
      div_value = 8'd5;
      step();
      div_value = 8'd6;
      step();
      div_load  = 1'b0;
      total++;
      if (div_ack !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL multi_load_pending: ack=%b busy=%b want 0 1", div_ack, busy);
      end
      step();
      // count==3: this load coincides with the TC.
      div_load  = 1'b1;
      div_value = 8'd7;
      step();
      div_load  = 1'b0;
      total++;
      if (tick !== 1'b1 || div_ack !== 1'b1 || busy !== 1'b1 || clk_out !== 1'b0) begin
         bad++;
         $display("FAIL multi_load_tc: tick=%b ack=%b busy=%b clk=%b want 1 1 1 0",
                  tick, div_ack, busy, clk_out);
      end
      wait_tick(n, a);
      total++;
      if (n !== 7 || a !== 1 || div_ack !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL multi_load_six: n=%0d acks=%0d ack=%b busy=%b want 7 1 1 0",
                  n, a, div_ack, busy);
      end
      wait_tick(n, a);
      total++;
      if (n !== 8 || a !== 0) begin
         bad++;
         $display("FAIL multi_load_seven: n=%0d acks=%0d want 8 0", n, a);
      end
   endtask

   task automatic test_reset_mid_drain();
      int n, a;
      int acks;
      do_reset();
      pulse_start();
      wait_tick(n, a);
      div_load  = 1'b1;
      div_value = 8'd9;
      step();
      div_load  = 1'b0;
      stop      = 1'b1;
      step();
      stop      = 1'b0;
      total++;
      if (busy !== 1'b1 || running !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_drain: busy=%b run=%b want 1 1", busy, running);
      end
      do_reset();
      total++;
      if ({tick, clk_out, div_ack, running, busy} !== 5'b0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got=%b want=00000",
                  {tick, clk_out, div_ack, running, busy});
      end
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (div_ack !== 1'b0 || busy !== 1'b0) acks++;
      end
      total++;
      if (acks !== 0) begin
         bad++;
         $display("FAIL mid_reset_no_ack: bad_cycles=%0d want=0", acks);
      end
      pulse_start();
      wait_tick(n, a);
      total++;
      if (n !== 4 || a !== 0 || clk_out !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_restart: n=%0d acks=%0d clk=%b want 4 0 1", n, a, clk_out);
      end
      wait_tick(n, a);
      total++;
      if (n !== 4 || clk_out !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_period: n=%0d clk=%b want 4 0", n, clk_out);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      div_load  = 1'b0;
      div_value = '0;
      test_reset();
      test_start();
      test_load_run();
      test_idle_load_zero();
      test_stop();
      test_back_to_back();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
